// File: rtl/t08_mem_arbiter_if.sv
// rtl/t08_mem_arbiter_if.sv - core request/response and memory-bus signal bundle for t08_mem_arbiter
interface t08_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_sel;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        err;
  logic        stall;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_busy;
  logic [31:0] bus_rdata;

  // slave: the arbiter's view; master: the core plus memory around it
  modport slave (
    input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, d_sel, bus_busy, bus_rdata,
    output if_instr, if_valid, d_rdata, d_valid, err, stall,
           bus_read, bus_write, bus_addr, bus_wdata, bus_sel
  );

  modport master (
    output if_req, if_addr, d_read, d_write, d_addr, d_wdata, d_sel, bus_busy, bus_rdata,
    input  if_instr, if_valid, d_rdata, d_valid, err, stall,
           bus_read, bus_write, bus_addr, bus_wdata, bus_sel
  );
endinterface

// File: rtl/t08_mem_arbiter.sv
// rtl/t08_mem_arbiter.sv - single-outstanding fetch/data memory arbiter with busy watchdog
module t08_mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              nrst,
  t08_mem_arbiter_if.slave  bus_if
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic            owner_data_q, owner_data_d;
  logic            is_write_q, is_write_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic [31:0]     d_rdata_q, d_rdata_d;
  logic [31:0]     bus_addr_q, bus_addr_d;
  logic [31:0]     bus_wdata_q, bus_wdata_d;
  logic [3:0]      bus_sel_q, bus_sel_d;
  logic            if_valid_q, if_valid_d;
  logic            d_valid_q, d_valid_d;
  logic            err_q, err_d;
  logic            bus_read_q, bus_read_d;
  logic            bus_write_q, bus_write_d;
  logic            finish;
  logic [31:0]     cap_data;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      owner_data_q <= 1'b0;
      is_write_q   <= 1'b0;
      wdog_q       <= '0;
      if_instr_q   <= '0;
      d_rdata_q    <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_sel_q    <= '0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      err_q        <= 1'b0;
      bus_read_q   <= 1'b0;
      bus_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      is_write_q   <= is_write_d;
      wdog_q       <= wdog_d;
      if_instr_q   <= if_instr_d;
      d_rdata_q    <= d_rdata_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_sel_q    <= bus_sel_d;
      if_valid_q   <= if_valid_d;
      d_valid_q    <= d_valid_d;
      err_q        <= err_d;
      bus_read_q   <= bus_read_d;
      bus_write_q  <= bus_write_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_data_d = owner_data_q;
    is_write_d   = is_write_q;
    wdog_d       = wdog_q;
    if_instr_d   = if_instr_q;
    d_rdata_d    = d_rdata_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_sel_d    = bus_sel_q;
    if_valid_d   = 1'b0;
    d_valid_d    = 1'b0;
    err_d        = 1'b0;
    bus_read_d   = 1'b0;
    bus_write_d  = 1'b0;
    finish       = 1'b0;
    cap_data     = '0;

    case (state_q)
      IDLE: begin
        if (bus_if.d_read || bus_if.d_write) begin
          // read+write together is serviced as a write
          owner_data_d = 1'b1;
          is_write_d   = bus_if.d_write;
          bus_addr_d   = bus_if.d_addr;
          bus_wdata_d  = bus_if.d_write ? bus_if.d_wdata : 32'h0;
          bus_sel_d    = bus_if.d_sel;
          bus_write_d  = bus_if.d_write;
          bus_read_d   = !bus_if.d_write;
          state_d      = ISSUE;
        end else if (bus_if.if_req) begin
          owner_data_d = 1'b0;
          is_write_d   = 1'b0;
          bus_addr_d   = bus_if.if_addr;
          bus_wdata_d  = 32'h0;
          bus_sel_d    = 4'hF;
          bus_read_d   = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: state_d = ARM;
      ARM: begin
        // memory needs a cycle to raise busy, so it is not looked at here
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!bus_if.bus_busy) begin
          finish   = 1'b1;
          cap_data = bus_if.bus_rdata;
        end else if (wdog_q == WDW'(TIMEOUT)) begin
          finish   = 1'b1;
          err_d    = 1'b1;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
        if (finish) begin
          state_d = DONE;
          if (!owner_data_q) begin
            if_instr_d = cap_data;
            if_valid_d = 1'b1;
          end else begin
            if (!is_write_q) d_rdata_d = cap_data;
            d_valid_d = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_if.stall = 1'b0;
    if (nrst) begin
      case (state_q)
        IDLE:             bus_if.stall = bus_if.if_req | bus_if.d_read | bus_if.d_write;
        ISSUE, ARM, WAIT: bus_if.stall = 1'b1;
        default:          bus_if.stall = 1'b0;
      endcase
    end
  end

  assign bus_if.if_instr  = if_instr_q;
  assign bus_if.if_valid  = if_valid_q;
  assign bus_if.d_rdata   = d_rdata_q;
  assign bus_if.d_valid   = d_valid_q;
  assign bus_if.err       = err_q;
  assign bus_if.bus_read  = bus_read_q;
  assign bus_if.bus_write = bus_write_q;
  assign bus_if.bus_addr  = bus_addr_q;
  assign bus_if.bus_wdata = bus_wdata_q;
  assign bus_if.bus_sel   = bus_sel_q;

endmodule

// File: tb/tb_t08_mem_arbiter.sv
// tb/tb_t08_mem_arbiter.sv - randomized self-checking bench for t08_mem_arbiter
module tb_t08_mem_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] exp_f_addr, exp_d_addr, exp_d_wdata;
  logic [3:0]  exp_d_sel;
  logic        exp_d_wr;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_rdata = 32'h0;

  t08_mem_arbiter_if bif ();

  t08_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk    (clk),
    .nrst   (nrst),
    .bus_if (bif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic raise_fetch(input logic [31:0] a);
    bif.if_req  = 1'b1;
    bif.if_addr = a;
    exp_f_addr  = a;
  endtask

  task automatic raise_data(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] w, input logic [3:0] s);
    bif.d_read  = rd;
    bif.d_write = wr;
    bif.d_addr  = a;
    bif.d_wdata = w;
    bif.d_sel   = s;
    exp_d_addr  = a;
    exp_d_wr    = wr;
    exp_d_wdata = wr ? w : 32'h0;
    exp_d_sel   = s;
  endtask

  // Called at the negedge of the IDLE cycle that sees the request (cycle 0);
  // returns at the negedge of the following IDLE cycle. Memory holds busy from
  // the ARM cycle for n WAIT cycles, so completion lands at 4+n, or TO+4 on timeout.
  task automatic serve(input bit is_data, input int n, input logic [31:0] cap, input int abort_at);
    bit   tmo;
    int   done_c;
    bit   wr;
    logic [4:0] exp_ctl;
    tmo    = (n > TO);
    done_c = tmo ? TO + 4 : n + 4;
    wr     = is_data && exp_d_wr;
    for (int c = 0; c <= done_c; c++) begin
      if (c > 0) @(negedge clk);
      bif.bus_busy  = (c >= 2) && (c <= n + 2);
      bif.bus_rdata = (c == n + 3) ? cap : $urandom;
      if (abort_at != 0 && c == abort_at) begin
        nrst = 1'b0;
        #1;
        check("rst_ctl", {bif.if_valid, bif.d_valid, bif.err, bif.bus_read, bif.bus_write}, 0);
        check("rst_data", bif.if_instr | bif.d_rdata | bif.bus_addr | bif.bus_wdata, 0);
        check("rst_sel", bif.bus_sel, 0);
        check("rst_stall", bif.stall, 0);
        m_instr = 32'h0;
        m_rdata = 32'h0;
        @(negedge clk);
        check("rst_hold_ctl", {bif.if_valid, bif.d_valid, bif.err, bif.bus_read, bif.bus_write}, 0);
        @(negedge clk);
        bif.bus_busy = 1'b0;
        nrst = 1'b1;
        return;
      end
      exp_ctl = {!is_data && c == done_c, is_data && c == done_c, tmo && c == done_c,
                 c == 1 && !wr, c == 1 && wr};
      check($sformatf("ctl c%0d", c),
            {bif.if_valid, bif.d_valid, bif.err, bif.bus_read, bif.bus_write}, exp_ctl);
      check($sformatf("stall c%0d", c), bif.stall, c != done_c);
      if (c == 1) begin
        check("bus_addr", bif.bus_addr, is_data ? exp_d_addr : exp_f_addr);
        check("bus_wdata", bif.bus_wdata, is_data ? exp_d_wdata : 32'h0);
        check("bus_sel", bif.bus_sel, is_data ? exp_d_sel : 4'hF);
        if (abort_at == 0) begin
          if (is_data) begin
            bif.d_addr  = $urandom;
            bif.d_wdata = $urandom;
            bif.d_sel   = 4'($urandom);
          end else begin
            bif.if_addr = $urandom;
          end
        end
      end
      if (c == 3 && abort_at == 0) begin
        check("latched_addr", bif.bus_addr, is_data ? exp_d_addr : exp_f_addr);
      end
      if (c == done_c) begin
        if (!is_data) m_instr = tmo ? 32'h0 : cap;
        else if (!wr) m_rdata = tmo ? 32'h0 : cap;
        check("if_instr", bif.if_instr, m_instr);
        check("d_rdata", bif.d_rdata, m_rdata);
        if (is_data) begin
          bif.d_read  = 1'b0;
          bif.d_write = 1'b0;
        end else begin
          bif.if_req = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bif.if_req = 1'b0; bif.if_addr = '0;
    bif.d_read = 1'b0; bif.d_write = 1'b0; bif.d_addr = '0; bif.d_wdata = '0; bif.d_sel = '0;
    bif.bus_busy = 1'b0; bif.bus_rdata = '0;

    // reset held with a pending fetch
    raise_fetch(32'h0000_0040);
    repeat (3) @(negedge clk);
    check("rst_ctl", {bif.if_valid, bif.d_valid, bif.err, bif.bus_read, bif.bus_write}, 0);
    check("rst_data", bif.if_instr | bif.d_rdata | bif.bus_addr | bif.bus_wdata, 0);
    check("rst_sel", bif.bus_sel, 0);
    check("rst_stall", bif.stall, 0);
    nrst = 1'b1;
    serve(1'b0, 0, 32'hA5A5_0001, 0);

    // idle: no request, no stall, no strobes
    @(negedge clk);
    check("idle_stall", bif.stall, 0);
    check("idle_ctl", {bif.if_valid, bif.d_valid, bif.err, bif.bus_read, bif.bus_write}, 0);

    raise_fetch(32'h0000_0010);
    serve(1'b0, 3, 32'h0000_0093, 0);

    raise_data(1'b0, 1'b1, 32'h0000_000C, 32'h7FFF_FFFF, 4'b0011);
    serve(1'b1, 1, 32'hDEAD_BEEF, 0);

    // simultaneous fetch and load: data first, fetch immediately after
    raise_fetch(32'h0000_2000);
    raise_data(1'b1, 1'b0, 32'h0000_3000, 32'h1111_1111, 4'b1100);
    serve(1'b1, 0, 32'h0BAD_F00D, 0);
    serve(1'b0, 2, 32'h1234_5678, 0);

    // watchdog boundaries: busy held for exactly TO cycles, TO+1, and stuck
    raise_data(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    serve(1'b1, TO, 32'hCAFE_0001, 0);
    raise_data(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'hF);
    serve(1'b1, TO + 1, 32'hCAFE_0002, 0);
    raise_fetch(32'h0000_0200);
    serve(1'b0, 40, 32'hCAFE_0003, 0);

    // reset during WAIT, then reissue of the still-pending load
    raise_data(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'b0101);
    serve(1'b1, 10, 32'hCAFE_0004, 5);
    serve(1'b1, 2, 32'hCAFE_0005, 0);

    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin raise_fetch($urandom); serve(1'b0, $urandom_range(0, TO + 3), $urandom, 0); end
        1: begin raise_data(1'b1, 1'b0, $urandom, $urandom, 4'($urandom));
                 serve(1'b1, $urandom_range(0, TO + 3), $urandom, 0); end
        2: begin raise_data(1'b0, 1'b1, $urandom, $urandom, 4'($urandom));
                 serve(1'b1, $urandom_range(0, TO + 3), $urandom, 0); end
        3: begin raise_data(1'b1, 1'b1, $urandom, $urandom, 4'($urandom));
                 serve(1'b1, $urandom_range(0, TO + 3), $urandom, 0); end
        4: begin raise_fetch($urandom);
                 raise_data(1'b1, 1'b0, $urandom, $urandom, 4'($urandom));
                 serve(1'b1, $urandom_range(0, TO + 3), $urandom, 0);
                 serve(1'b0, $urandom_range(0, TO + 3), $urandom, 0); end
        default: begin
          @(negedge clk);
          check("idle_stall", bif.stall, 0);
          check("idle_ctl", {bif.if_valid, bif.d_valid, bif.err, bif.bus_read, bif.bus_write}, 0);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
